// File: rtl/aes_pixel_packer.sv
// Packs a stream of pixel bytes into 128-bit plaintext blocks for the AES core,
// padding a short final block and holding each block under valid/ready.
module aes_pixel_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         IDX_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pix_data,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic [127:0]     blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             blk_last,
  output logic [3:0]       blk_pad,
  output logic [IDX_W-1:0] blk_index
);

  typedef enum logic {FILL, HOLD} state_e;

  state_e             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [127:0]       data_q,  data_d;
  logic               last_q,  last_d;
  logic [3:0]         pad_q,   pad_d;
  logic [IDX_W-1:0]   index_q, index_d;

  logic               byte_acc;
  logic               blk_acc;
  logic [3:0]         slot;
  logic               close;

  // Byte 0 lands in [127:120]. Writing slot 0 starts a fresh block, so the
  // remaining slots are cleared; a closing byte pads every slot after it.
  function automatic logic [127:0] pack(input logic [127:0] cur,
                                        input logic [3:0]   at,
                                        input logic [7:0]   b,
                                        input logic         fin);
    logic [127:0] r;
    logic [3:0]   ks;
    r = cur;
    for (int k = 0; k < 16; k++) begin
      ks = k[3:0];
      if (ks == at)             r[127-8*k -: 8] = b;
      else if (fin && ks > at)  r[127-8*k -: 8] = PAD_BYTE;
      else if (at == 4'd0)      r[127-8*k -: 8] = 8'h00;
    end
    return r;
  endfunction

  assign blk_valid = (state_q == HOLD);
  assign pix_ready = (state_q == FILL) ? 1'b1 : blk_ready;
  assign byte_acc  = pix_valid & pix_ready;
  assign blk_acc   = blk_valid & blk_ready;

  assign blk_data  = data_q;
  assign blk_last  = last_q;
  assign blk_pad   = pad_q;
  assign blk_index = index_q;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    last_d  = last_q;
    pad_d   = pad_q;
    index_d = index_q;
    slot    = count_q;
    close   = 1'b0;

    if (blk_acc) begin
      index_d = index_q + 1'b1;
      last_d  = 1'b0;
      pad_d   = 4'd0;
      count_d = 4'd0;
      state_d = FILL;
    end

    // In HOLD a byte can only arrive together with the block accept, so it
    // opens the next block at slot 0; a closing byte then re-enters HOLD.
    if (byte_acc) begin
      slot   = (state_q == HOLD) ? 4'd0 : count_q;
      close  = (slot == 4'd15) || pix_last;
      data_d = pack(data_q, slot, pix_data, close);
      if (close) begin
        state_d = HOLD;
        pad_d   = 4'd15 - slot;
        last_d  = pix_last;
        count_d = 4'd0;
      end else begin
        count_d = slot + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= 4'd0;
      data_q  <= '0;
      last_q  <= 1'b0;
      pad_q   <= 4'd0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      index_q <= index_d;
    end
  end

endmodule

// File: tb/tb_aes_pixel_packer.sv
// Directed bench for aes_pixel_packer: packing order, padding, back-pressure,
// streaming throughput, reset recovery and the HOLD-plus-last corner case.
module tb_aes_pixel_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   pix_data;
  logic         pix_valid;
  logic         pix_last;
  logic         pix_ready;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_last;
  logic [3:0]   blk_pad;
  logic [15:0]  blk_index;

  int vectors = 0;
  int miscompares = 0;

  aes_pixel_packer dut (
    .clk       (clk),
    .rst       (rst),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_last  (pix_last),
    .pix_ready (pix_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .blk_pad   (blk_pad),
    .blk_index (blk_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Block of 16 bytes base, base+step, base+2*step, ...
  function automatic logic [127:0] seq_blk(input logic [7:0] base, input logic [7:0] step);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = 8'(base + step * k);
    return r;
  endfunction

  task automatic send(input logic [7:0] b, input logic last);
    pix_valid = 1'b1;
    pix_data  = b;
    pix_last  = last;
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  logic [127:0] hold_exp;
  int           valid_cnt;
  int           ready_gaps;
  int           stable_bad;
  int           ready_bad;

  initial begin
    rst = 1'b1; pix_data = 8'h00; pix_valid = 1'b0; pix_last = 1'b0; blk_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_data",  blk_data,  128'h0);
    chk("rst_valid", blk_valid, 1'b0);
    chk("rst_last",  blk_last,  1'b0);
    chk("rst_pad",   blk_pad,   4'd0);
    chk("rst_index", blk_index, 16'd0);
    chk("rst_ready", pix_ready, 1'b1);

    // Full block 00..0F, valid for exactly one cycle.
    blk_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("b0_valid", blk_valid, 1'b1);
    chk("b0_data",  blk_data,  128'h000102030405060708090A0B0C0D0E0F);
    chk("b0_pad",   blk_pad,   4'd0);
    chk("b0_last",  blk_last,  1'b0);
    chk("b0_index", blk_index, 16'd0);
    tick();
    chk("b0_one_cycle", blk_valid, 1'b0);
    chk("b0_index_inc", blk_index, 16'd1);

    // Short final block with padding.
    blk_ready = 1'b0;
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    send(8'hEE, 1'b1);
    chk("pad_valid", blk_valid, 1'b1);
    chk("pad_data",  blk_data,  128'hAABBCCDDEE0000000000000000000000);
    chk("pad_pad",   blk_pad,   4'd11);
    chk("pad_last",  blk_last,  1'b1);
    chk("pad_index", blk_index, 16'd1);
    blk_ready = 1'b1;
    tick();
    chk("pad_accept_valid", blk_valid, 1'b0);
    chk("pad_accept_last",  blk_last,  1'b0);
    chk("pad_accept_pad",   blk_pad,   4'd0);

    // Back-pressure: block held for 10 cycles while a byte waits.
    blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
    hold_exp = seq_blk(8'h40, 8'h01);
    chk("bp_data", blk_data, hold_exp);
    stable_bad = 0; ready_bad = 0;
    pix_valid = 1'b1; pix_data = 8'h50;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (pix_ready !== 1'b0) ready_bad++;
      if (blk_data !== hold_exp || blk_valid !== 1'b1) stable_bad++;
      tick();
    end
    chk("bp_ready_low", 32'(ready_bad), 32'd0);
    chk("bp_stable",    32'(stable_bad), 32'd0);
    chk("bp_index",     blk_index, 16'd2);
    blk_ready = 1'b1;
    #1;
    chk("bp_ready_pass", pix_ready, 1'b1);
    send(8'h50, 1'b0);
    chk("bp_accept_index", blk_index, 16'd3);
    chk("bp_accept_valid", blk_valid, 1'b0);
    for (int i = 1; i < 16; i++) send(8'(8'h50 + i), 1'b0);
    chk("bp_next_data",  blk_data,  seq_blk(8'h50, 8'h01));
    chk("bp_next_index", blk_index, 16'd3);
    tick();

    // Streaming 48 bytes with blk_ready high: no bubble, three blocks.
    rst = 1'b1; tick(); rst = 1'b0;
    valid_cnt = 0; ready_gaps = 0;
    for (int i = 0; i < 48; i++) begin
      pix_valid = 1'b1; pix_data = 8'(i);
      #1;
      if (pix_ready !== 1'b1) ready_gaps++;
      if (blk_valid === 1'b1) valid_cnt++;
      if (i == 16) begin
        chk("st_b0_data",  blk_data,  seq_blk(8'h00, 8'h01));
        chk("st_b0_index", blk_index, 16'd0);
      end
      if (i == 32) begin
        chk("st_b1_data",  blk_data,  seq_blk(8'h10, 8'h01));
        chk("st_b1_index", blk_index, 16'd1);
      end
      tick();
    end
    pix_valid = 1'b0;
    chk("st_no_gap",     32'(ready_gaps), 32'd0);
    chk("st_valid_cnt",  32'(valid_cnt),  32'd2);
    chk("st_b2_valid",   blk_valid, 1'b1);
    chk("st_b2_data",    blk_data,  seq_blk(8'h20, 8'h01));
    chk("st_b2_index",   blk_index, 16'd2);
    tick();

    // Reset mid-block discards the partial block.
    for (int i = 0; i < 7; i++) send(8'(8'h90 + i), 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("mr_data",  blk_data,  128'h0);
    chk("mr_valid", blk_valid, 1'b0);
    chk("mr_index", blk_index, 16'd0);
    chk("mr_pad",   blk_pad,   4'd0);
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("mr_blk_data",  blk_data,  seq_blk(8'h00, 8'h01));
    chk("mr_blk_index", blk_index, 16'd0);
    tick();

    // AES vector plaintext, pix_last on the 16th byte.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h11 * i), (i == 15));
    chk("aes_data", blk_data, 128'h00112233445566778899AABBCCDDEEFF);
    chk("aes_pad",  blk_pad,  4'd0);
    chk("aes_last", blk_last, 1'b1);

    // Block accept and a lone last byte on the same edge.
    blk_ready = 1'b1;
    send(8'h77, 1'b1);
    chk("hl_valid", blk_valid, 1'b1);
    chk("hl_data",  blk_data,  128'h77000000000000000000000000000000);
    chk("hl_pad",   blk_pad,   4'd15);
    chk("hl_last",  blk_last,  1'b1);
    chk("hl_index", blk_index, 16'd1);
    tick();
    chk("hl_accept_valid", blk_valid, 1'b0);
    chk("hl_accept_index", blk_index, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
